// File: rtl/bfm_seq_ctrl.sv
// bfm_seq_ctrl: splits byte packets into operand pairs for the BFM and streams back checksummed results
module bfm_seq_ctrl #(
   parameter int PKT_BYTES = 32,
   parameter int BFM_LAT   = 1
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   start_i,
   input  logic [15:0]            num_pkts_i,
   input  logic                   pkt_valid_i,
   input  logic [8*PKT_BYTES-1:0] pkt_data_i,
   output logic                   pkt_ready_o,
   output logic [7:0]             A_s,
   output logic [7:0]             B_s,
   output logic                   op_valid_o,
   input  logic [7:0]             res_i,
   output logic                   res_valid_o,
   output logic [7:0]             res_data_o,
   output logic [15:0]            checksum_o,
   output logic [31:0]            pair_cnt_o,
   output logic                   busy_o,
   output logic                   done_o
);
   localparam int NP = PKT_BYTES / 2;
   localparam int IW = (NP > 1) ? $clog2(NP) : 1;
   typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, DONE} state_t;
   state_t                 state_q, state_d;
   logic [8*PKT_BYTES-1:0] pkt_q, pkt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [15:0]            rem_q, rem_d;
   logic [31:0]            pc_q, pc_d;
   logic [BFM_LAT-1:0]     dl_q;
   logic                   rv_q;
   logic [7:0]             rd_q;
   logic [15:0]            cs_q;
   logic                   clr, last_pair, tap;
   assign last_pair   = idx_q == IW'(NP - 1);
   assign tap         = dl_q[BFM_LAT-1];
   assign pkt_ready_o = state_q == LOAD;
   assign op_valid_o  = state_q == ISSUE;
   assign busy_o      = state_q != IDLE;
   assign done_o      = state_q == DONE;
   assign A_s         = pkt_q[{idx_q, 4'd0} +: 8];
   assign B_s         = pkt_q[{idx_q, 4'd8} +: 8];
   assign res_valid_o = rv_q;
   assign res_data_o  = rd_q;
   assign checksum_o  = cs_q;
   assign pair_cnt_o  = pc_q;
   // sequencer state and per-run bookkeeping registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         pkt_q   <= '0;
         idx_q   <= '0;
         rem_q   <= '0;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pkt_q   <= pkt_d;
         idx_q   <= idx_d;
         rem_q   <= rem_d;
         pc_q    <= pc_d;
      end
   end
   // next-state: start/load/issue pairs, then wait for the result pipe to empty
   always_comb begin
      state_d = state_q;
      pkt_d   = pkt_q;
      idx_d   = idx_q;
      rem_d   = rem_q;
      pc_d    = pc_q;
      clr     = 1'b0;
      case (state_q)
         IDLE: if (start_i) begin
            rem_d   = num_pkts_i;
            pc_d    = '0;
            clr     = 1'b1;
            state_d = (num_pkts_i == 16'd0) ? DONE : LOAD;
         end
         LOAD: if (pkt_valid_i) begin
            pkt_d   = pkt_data_i;
            idx_d   = '0;
            rem_d   = rem_q - 16'd1;
            state_d = ISSUE;
         end
         ISSUE: begin
            pc_d  = pc_q + 32'd1;
            idx_d = last_pair ? idx_q : idx_q + IW'(1);
            if (last_pair) state_d = (rem_q != 16'd0) ? LOAD : DRAIN;
         end
         DRAIN: if (dl_q == '0) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // result capture: delay line tracks live pairs, tap samples the BFM output
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         dl_q <= '0;
         rv_q <= 1'b0;
         rd_q <= '0;
         cs_q <= '0;
      end else begin
         dl_q <= (dl_q << 1) | BFM_LAT'(op_valid_o);
         rv_q <= tap;
         if (tap) rd_q <= res_i;
         cs_q <= clr ? 16'd0 : cs_q + (tap ? {8'd0, res_i} : 16'd0);
      end
   end
endmodule

// File: tb/tb_bfm_seq_ctrl.sv
// tb_bfm_seq_ctrl: randomized runs checked cycle by cycle against a schedule derived from the timing rules
module tb_bfm_seq_ctrl;
   localparam int PB = 4, LAT = 1, NP = PB / 2, N = 4096;
   logic clk = 1'b0;
   logic reset_i, start_i, pkt_valid_i, pkt_ready_o, op_valid_o, res_valid_o, busy_o, done_o;
   logic [15:0] num_pkts_i, checksum_o;
   logic [8*PB-1:0] pkt_data_i;
   logic [7:0] A_s, B_s, res_i, res_data_o;
   logic [31:0] pair_cnt_o;
   int cyc = 0, n_cmp = 0, n_bad = 0;
   bit s_rst[N], s_start[N], s_valid[N];
   logic [15:0] s_num[N];
   logic [31:0] s_data[N];
   bit e_rst[N], e_clr[N], e_ready[N], e_busy[N], e_done[N], e_opv[N], e_rv[N];
   bit [7:0] e_a[N], e_b[N], e_rd[N];
   bit [7:0] m_a, m_b, m_rd;
   bit [15:0] m_cs;
   bit [31:0] m_pc;
   logic [31:0] q_pkt[$];
   int q_dly[$];
   int t, fin, r, fin2, n;

   bfm_seq_ctrl #(.PKT_BYTES(PB), .BFM_LAT(LAT)) dut (
      .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .num_pkts_i(num_pkts_i),
      .pkt_valid_i(pkt_valid_i), .pkt_data_i(pkt_data_i), .pkt_ready_o(pkt_ready_o),
      .A_s(A_s), .B_s(B_s), .op_valid_o(op_valid_o), .res_i(res_i),
      .res_valid_o(res_valid_o), .res_data_o(res_data_o), .checksum_o(checksum_o),
      .pair_cnt_o(pair_cnt_o), .busy_o(busy_o), .done_o(done_o));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // bfm stand-in: one-cycle adder
   always @(posedge clk) res_i <= A_s + B_s;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endfunction

   task automatic at(input int c);
      @(negedge clk);
      while (cyc < c) @(negedge clk);
      if (cyc != c) chk("at_overrun", 32'(cyc), 32'(c));
   endtask

   // schedule a run whose start_i is driven in cycle ts; returns the done cycle
   task automatic plan(input int ts, input int np, output int f);
      int l, h, c;
      s_start[ts] = 1'b1;
      s_num[ts] = 16'(np);
      e_clr[ts+1] = 1'b1;
      if (np == 0) begin
         e_busy[ts+1] = 1'b1;
         e_done[ts+1] = 1'b1;
         f = ts + 1;
         return;
      end
      l = ts + 1;
      for (int i = 0; i < np; i++) begin
         h = l + q_dly[i];
         for (c = l; c <= h; c++) begin
            e_ready[c] = 1'b1;
            s_valid[c] = 1'b0;
         end
         s_valid[h] = 1'b1;
         s_data[h] = q_pkt[i];
         for (int k = 0; k < NP; k++) begin
            c = h + 1 + k;
            e_opv[c] = 1'b1;
            e_a[c] = q_pkt[i][16*k +: 8];
            e_b[c] = q_pkt[i][16*k+8 +: 8];
            e_rv[c+LAT+1] = 1'b1;
            e_rd[c+LAT+1] = 8'(e_a[c] + e_b[c]);
         end
         l = h + NP + 1;
      end
      f = l - 1 + LAT + 2;
      for (c = ts + 1; c <= f; c++) begin
         e_busy[c] = 1'b1;
         if ($urandom_range(7) == 0) s_start[c] = 1'b1;
      end
      e_done[f] = 1'b1;
   endtask

   // reset driven in cycle rc wipes everything the run would still have produced
   task automatic mid_reset(input int rc, input int f);
      s_rst[rc] = 1'b1;
      e_rst[rc+1] = 1'b1;
      for (int c = rc + 1; c <= f + LAT + 2; c++) begin
         s_start[c] = 1'b0;
         e_clr[c] = 1'b0; e_ready[c] = 1'b0; e_busy[c] = 1'b0; e_done[c] = 1'b0;
         e_opv[c] = 1'b0; e_rv[c] = 1'b0;
      end
   endtask

   // driver: apply the planned stimulus for each cycle
   initial begin
      #1;
      forever begin
         reset_i = s_rst[cyc];
         start_i = s_start[cyc];
         num_pkts_i = s_num[cyc];
         pkt_valid_i = s_valid[cyc];
         pkt_data_i = s_data[cyc];
         @(posedge clk);
         #1;
      end
   end

   // compare: held values and running sums follow the scheduled events
   initial begin
      forever begin
         @(negedge clk);
         if (cyc >= 1 && cyc < N) begin
            if (e_rst[cyc]) begin m_a = 0; m_b = 0; m_rd = 0; m_cs = 0; m_pc = 0; end
            if (e_clr[cyc]) begin m_cs = 0; m_pc = 0; end
            if (e_opv[cyc]) begin m_a = e_a[cyc]; m_b = e_b[cyc]; end
            if (e_rv[cyc]) begin m_rd = e_rd[cyc]; m_cs = m_cs + {8'h00, e_rd[cyc]}; end
            chk("pkt_ready", pkt_ready_o, e_ready[cyc]);
            chk("busy", busy_o, e_busy[cyc]);
            chk("done", done_o, e_done[cyc]);
            chk("op_valid", op_valid_o, e_opv[cyc]);
            chk("A_s", A_s, m_a);
            chk("B_s", B_s, m_b);
            chk("res_valid", res_valid_o, e_rv[cyc]);
            chk("res_data", res_data_o, m_rd);
            chk("checksum", checksum_o, m_cs);
            chk("pair_cnt", pair_cnt_o, m_pc);
            if (e_opv[cyc]) m_pc = m_pc + 1;
         end
      end
   end

   initial begin
      for (int c = 0; c < N; c++) begin
         s_valid[c] = 1'($urandom);
         s_data[c] = $urandom;
         s_num[c] = 16'($urandom);
      end
      for (int c = 0; c < 3; c++) begin
         s_rst[c] = 1'b1;
         e_rst[c+1] = 1'b1;
      end
      at(2);
      chk("lit_rst_busy", busy_o, 0);
      chk("lit_rst_cs", checksum_o, 0);
      at(6);
      chk("lit_idle_ready", pkt_ready_o, 0);
      t = 8;
      q_pkt = '{32'h04030201};
      q_dly = '{0};
      plan(t, 1, fin);
      at(t + 2);
      chk("lit_a0", A_s, 8'h01);
      chk("lit_b0", B_s, 8'h02);
      at(t + 4);
      chk("lit_r0", res_data_o, 8'h03);
      at(t + 5);
      chk("lit_r1", res_data_o, 8'h07);
      at(t + 6);
      chk("lit_done", done_o, 1);
      chk("lit_cs", checksum_o, 16'h000A);
      chk("lit_pc", pair_cnt_o, 2);
      t = fin + 2;
      plan(t, 0, fin);
      at(t + 1);
      chk("lit_zero_done", done_o, 1);
      at(t + 2);
      chk("lit_zero_busy", busy_o, 0);
      t = fin + 3;
      q_pkt = '{32'h04030201, 32'h08070605};
      q_dly = '{0, 5};
      plan(t, 2, fin);
      at(t + 9);
      chk("lit_stall_opv", op_valid_o, 0);
      at(fin);
      chk("lit_stall_cs", checksum_o, 16'h0024);
      chk("lit_stall_pc", pair_cnt_o, 4);
      t = fin + 2;
      q_pkt = '{$urandom, $urandom, $urandom};
      q_dly = '{0, 0, 0};
      plan(t, 3, fin);
      r = t + 2;
      mid_reset(r, fin);
      at(r + 1);
      chk("lit_mr_busy", busy_o, 0);
      chk("lit_mr_opv", op_valid_o, 0);
      chk("lit_mr_a", A_s, 0);
      chk("lit_mr_pc", pair_cnt_o, 0);
      t = r + 3;
      q_pkt = '{$urandom};
      q_dly = '{1};
      plan(t, 1, fin2);
      at(fin2);
      chk("lit_fresh_done", done_o, 1);
      t = fin2 + 2;
      q_pkt = '{32'h02FF02FF};
      q_dly = '{0};
      plan(t, 1, fin);
      s_start[t+2] = 1'b1;
      at(fin - 1);
      chk("lit_ovf_rd", res_data_o, 8'h01);
      at(fin);
      chk("lit_ovf_cs", checksum_o, 16'h0002);
      t = fin + 1;
      for (int i = 0; i < 25; i++) begin
         n = int'($urandom_range(4));
         q_pkt.delete();
         q_dly.delete();
         for (int j = 0; j < n; j++) begin
            q_pkt.push_back($urandom);
            q_dly.push_back(int'($urandom_range(3)));
         end
         plan(t, n, fin);
         if (n > 0 && $urandom_range(3) == 0) begin
            r = int'($urandom_range(fin, t + 1));
            mid_reset(r, fin);
            at(r + 1);
            t = r + 2 + int'($urandom_range(2));
         end else begin
            at(fin);
            t = fin + 1 + int'($urandom_range(2));
         end
      end
      at(t + 4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/bfm_seq_ctrl.md
# bfm_seq_ctrl

Run sequencer for the operand BFM. Accepts wide byte packets from the DPI packet source, splits each packet into (A, B) operand pairs, and issues one pair per cycle on A_s/B_s. It captures the BFM result after a fixed latency, streams the results out with a running checksum, and pulses done when the programmed number of packets has fully drained. Sits between the DPI packet generator and the bfm instance in the simulation top.

## Interface
- PKT_BYTES, 32: bytes per packet; must be even; packet width 8*PKT_BYTES.
- BFM_LAT, 1: cycles from A_s/B_s presented to the valid res_o from the bfm; range 1..8.

- clk_i  in  1  clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  run start pulse; sampled only in IDLE.
- num_pkts_i  in  16  packets in the run; latched on accepted start.
- pkt_valid_i  in  1  packet available.
- pkt_data_i  in  8*PKT_BYTES  packet; byte k = bits [8k+7:8k].
- pkt_ready_o  out  1  packet accept; valid&ready = transfer.
- A_s  out  8  operand A to bfm.
- B_s  out  8  operand B to bfm.
- op_valid_o  out  1  A_s/B_s carry a live pair this cycle.
- res_i  in  8  bfm res_o.
- res_valid_o  out  1  res_data_o holds a captured result.
- res_data_o  out  8  captured result.
- checksum_o  out  16  sum of captured results mod 2^16.
- pair_cnt_o  out  32  pairs issued this run; wraps.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle run-complete pulse.

## Operation
- States: IDLE, LOAD, ISSUE, DRAIN, DONE.
- IDLE: start_i=1 latches num_pkts_i, clears checksum_o and pair_cnt_o, and moves to LOAD. If num_pkts_i=0, it moves to DONE instead.
- LOAD: pkt_ready_o=1 (combinational from state only). On handshake, latch pkt_data_i, clear pair index, decrement packets-remaining, and move to ISSUE.
- ISSUE: lasts PKT_BYTES/2 cycles. In pair index k: op_valid_o=1, A_s=byte 2k, B_s=byte 2k+1, and pair_cnt_o increments. After the last pair:
  - go to LOAD if packets remain;
  - otherwise go to DRAIN.
- DRAIN: wait until the delay line holds no live entries and the last result has been emitted, then go to DONE.
- DONE: done_o=1 for exactly one cycle, then go to IDLE.
- Result capture: a BFM_LAT-deep shift register carries op_valid_o. When the tap is high, res_i is sampled. The next cycle gives res_valid_o=1 and res_data_o=sampled value, and checksum_o += zero-extended res_data_o.
- Results from packet n may emit while the block is in LOAD/ISSUE for packet n+1. Capture is independent of state.
- No backpressure on the result stream.

## Timing
- Reset (reset_i=1 at an edge) puts every output at 0: A_s, B_s, op_valid_o, res_valid_o, res_data_o, checksum_o, pair_cnt_o, busy_o, done_o, pkt_ready_o. It returns the FSM to IDLE and flushes the delay line.
- Reset mid-run discards in-flight results. No done_o pulse follows.
- start_i at edge t puts LOAD in cycle t+1. pkt_ready_o is high from t+1 until the handshake cycle inclusive.
- Handshake at edge h: first pair on A_s/B_s with op_valid_o=1 in cycle h+1.
- A pair live in cycle c produces res_valid_o in cycle c+BFM_LAT+1.
- Consecutive packets have at least 1 bubble cycle (LOAD) between their ISSUE bursts.
- A_s/B_s hold their last values when op_valid_o=0.
- If start_i arrives while busy_o=1, it is ignored. pkt_valid_i outside LOAD is ignored.
- With num_pkts_i=0: start at edge t gives done_o in cycle t+1. No pkt_ready_o and no op_valid_o occur.
- With num_pkts_i≠0: done_o fires in the cycle after the final res_valid_o.
- pair_cnt_o wraps at 2^32. checksum_o wraps at 2^16. res_data_o is not widened.

## Test plan
Bench settings: PKT_BYTES=4, BFM_LAT=1, bfm model res = A+B (8-bit).
- Reset: hold reset_i 3 cycles -> all outputs 0, busy_o=0; release -> pkt_ready_o stays 0 with no start.
- Single packet: num_pkts=1, pkt 0x04030201 -> op pairs (01,02) then (03,04) on consecutive cycles. Expected results:
  - res_valid_o with 0x03 then 0x07, 2 cycles after each issue;
  - checksum_o=0x000A, pair_cnt_o=2;
  - done_o exactly once, in the cycle after the 0x07 result.
- Zero-length run: num_pkts=0, start -> done_o next cycle, busy_o high one cycle, no pkt_ready_o, no op_valid_o.
- Stalled source: num_pkts=2, second pkt_valid_i delayed 5 cycles, pkts 0x04030201 and 0x08070605 -> op_valid_o low through the gap, results 03,07,0B,0F, checksum 0x0024, pair_cnt 4, one done_o.
- Mid-run reset: assert reset_i during ISSUE -> next cycle all outputs 0, no further res_valid_o or done_o. A fresh start then completes normally.
- Overflow and ignored start: pkt 0x02FF02FF, start_i pulsed again during ISSUE -> second start ignored. Results 0x01, 0x01; checksum 0x0002; one done_o.
